// File: rtl/fnd_pkg.sv
// Shared 7-segment constants and decode for the FND display blocks.
// Segment order is {dp,g,f,e,d,c,b,a}, active-low; every pattern leaves dp unlit.
package fnd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Non-BCD nibbles blank the digit rather than showing garbage.
  function automatic logic [7:0] seg_decode(input logic [3:0] digit, input logic dp_on);
    logic [7:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return dp_on ? (pat & 8'h7F) : pat;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler emitting a one-cycle tick every CLK_HZ/OUT_HZ enabled cycles.
// Counter is held at zero while disabled or cleared, so a restart always takes a full period.
module tick_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int OUT_HZ = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_HZ / OUT_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || !en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fnd_updown_counter.sv
// DIGITS-wide BCD up/down counter with run/clear and multiplexed active-low 7-segment drive.
// Count steps one edge after its tick; fnd_digit/fnd_data are registered one cycle behind the scan index.
module fnd_updown_counter
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int SCAN_HZ = 1000,
  parameter int DIGITS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              clear,
  input  logic              mode,
  output logic [DIGITS-1:0] fnd_digit,
  output logic [7:0]        fnd_data
);

  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE_HOT0 = {{(DIGITS-1){1'b0}}, 1'b1};

  logic              count_tick;
  logic              scan_tick;
  logic [3:0]        bcd [DIGITS];
  logic [DIGITS-1:0] step;
  logic [IW-1:0]     idx;
  logic [7:0]        seg;

  tick_gen #(.CLK_HZ(CLK_HZ), .OUT_HZ(TICK_HZ)) u_count_tick (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .clr   (clear),
    .tick  (count_tick)
  );

  tick_gen #(.CLK_HZ(CLK_HZ), .OUT_HZ(SCAN_HZ)) u_scan_tick (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (1'b0),
    .tick  (scan_tick)
  );

  // step[i] marks digit i changing this cycle; it ripples up through digits sitting at their wrap value.
  assign step[0] = count_tick;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i < DIGITS - 1) begin : g_carry
      logic at_limit;
      assign at_limit  = mode ? (bcd[i] == 4'd0) : (bcd[i] == BCD_MAX);
      assign step[i+1] = step[i] && at_limit;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        bcd[i] <= 4'd0;
      end else if (clear) begin
        bcd[i] <= 4'd0;
      end else if (step[i]) begin
        if (mode) begin
          bcd[i] <= (bcd[i] == 4'd0) ? BCD_MAX : bcd[i] - 4'd1;
        end else begin
          bcd[i] <= (bcd[i] == BCD_MAX) ? 4'd0 : bcd[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (scan_tick) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  assign seg = seg_decode(bcd[idx], run && (idx == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fnd_digit <= ~ONE_HOT0;
      fnd_data  <= SEG_0;
    end else begin
      fnd_digit <= ~(ONE_HOT0 << idx);
      fnd_data  <= seg;
    end
  end

endmodule

// File: tb/tb_fnd_updown_counter.sv
// Directed bench for fnd_updown_counter: count value is recovered from the scanned display.
// CLK_HZ=100, TICK_HZ=10, SCAN_HZ=50, DIGITS=4.
module tb_fnd_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       clear = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] fnd_digit;
  logic [7:0] fnd_data;

  int n_cmp = 0;
  int n_bad = 0;

  fnd_updown_counter #(
    .CLK_HZ  (100),
    .TICK_HZ (10),
    .SCAN_HZ (50),
    .DIGITS  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .clear     (clear),
    .mode      (mode),
    .fnd_digit (fnd_digit),
    .fnd_data  (fnd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] seg2bcd(input logic [6:0] s);
    case (s)
      7'h40:   return 4'd0;
      7'h79:   return 4'd1;
      7'h24:   return 4'd2;
      7'h30:   return 4'd3;
      7'h19:   return 4'd4;
      7'h12:   return 4'd5;
      7'h02:   return 4'd6;
      7'h78:   return 4'd7;
      7'h00:   return 4'd8;
      7'h10:   return 4'd9;
      default: return 4'hF;
    endcase
  endfunction

  // One full scan period (8 cycles) visits every digit; unseen digits stay F.
  task automatic read_count(output logic [15:0] v);
    logic [15:0] acc;
    acc = 16'hFFFF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (fnd_digit == ~(4'b0001 << d)) acc[d*4 +: 4] = seg2bcd(fnd_data[6:0]);
      end
    end
    v = acc;
  endtask

  task automatic run_cycles(input int n);
    @(negedge clk) run = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk) run = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (fnd_digit !== 4'b1110) begin
      n_bad++; $display("FAIL reset_digit: got %b, want 1110", fnd_digit);
    end
    n_cmp++;
    if (fnd_data !== 8'hC0) begin
      n_bad++; $display("FAIL reset_data: got %h, want C0", fnd_data);
    end
    @(negedge clk) reset = 1'b0;
    read_count(v);
    n_cmp++;
    if (v !== 16'h0000) begin
      n_bad++; $display("FAIL reset_count: got %h, want 0000", v);
    end
  endtask

  task automatic test_count_up_scan;
    logic [15:0] v;
    logic [3:0]  prev;
    logic [3:0]  ed [4];
    logic [7:0]  ea [4];
    bit          found;
    ed = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    ea = '{8'h24, 8'hF9, 8'hC0, 8'hC0};
    mode = 1'b0;
    run_cycles(120);
    read_count(v);
    n_cmp++;
    if (v !== 16'h0012) begin
      n_bad++; $display("FAIL up_12: got %h, want 0012", v);
    end
    // Align to the first cycle digit 3 is shown, then run one tick period while watching the walk.
    found = 1'b0;
    prev = fnd_digit;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge clk);
      if (fnd_digit == 4'b0111 && prev != 4'b0111) found = 1'b1;
      prev = fnd_digit;
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL scan_align: got digit %b, want entry into 0111", fnd_digit);
    end
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1 || i == 3 || i == 5 || i == 7) begin
        n_cmp++;
        if (fnd_digit !== ed[i/2] || fnd_data !== ea[i/2]) begin
          n_bad++;
          $display("FAIL scan_walk%0d: got %b/%h, want %b/%h", i/2, fnd_digit, fnd_data, ed[i/2], ea[i/2]);
        end
      end
    end
    run = 1'b0;
    read_count(v);
    n_cmp++;
    if (v !== 16'h0013) begin
      n_bad++; $display("FAIL up_13: got %h, want 0013", v);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] v;
    mode = 1'b1;
    run_cycles(130);
    read_count(v);
    n_cmp++;
    if (v !== 16'h0000) begin
      n_bad++; $display("FAIL down_to_0: got %h, want 0000", v);
    end
    run_cycles(10);
    read_count(v);
    n_cmp++;
    if (v !== 16'h9999) begin
      n_bad++; $display("FAIL down_wrap: got %h, want 9999", v);
    end
    mode = 1'b0;
    run_cycles(10);
    read_count(v);
    n_cmp++;
    if (v !== 16'h0000) begin
      n_bad++; $display("FAIL up_wrap: got %h, want 0000", v);
    end
    run_cycles(9990);
    read_count(v);
    n_cmp++;
    if (v !== 16'h0999) begin
      n_bad++; $display("FAIL up_999: got %h, want 0999", v);
    end
    run_cycles(10);
    read_count(v);
    n_cmp++;
    if (v !== 16'h1000) begin
      n_bad++; $display("FAIL up_carry: got %h, want 1000", v);
    end
    mode = 1'b1;
    run_cycles(10);
    read_count(v);
    n_cmp++;
    if (v !== 16'h0999) begin
      n_bad++; $display("FAIL down_borrow: got %h, want 0999", v);
    end
    mode = 1'b0;
  endtask

  task automatic test_hold;
    logic [15:0] v;
    int lit;
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    read_count(v);
    n_cmp++;
    if (v !== 16'h0000) begin
      n_bad++; $display("FAIL clear_stopped: got %h, want 0000", v);
    end
    run_cycles(50);
    repeat (50) @(negedge clk);
    read_count(v);
    n_cmp++;
    if (v !== 16'h0005) begin
      n_bad++; $display("FAIL hold_5: got %h, want 0005", v);
    end
    lit = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (fnd_data[7] === 1'b0) lit++;
    end
    n_cmp++;
    if (lit != 0) begin
      n_bad++; $display("FAIL hold_dp: dp lit in %0d samples, want 0", lit);
    end
    run_cycles(9);
    read_count(v);
    n_cmp++;
    if (v !== 16'h0005) begin
      n_bad++; $display("FAIL restart_9cyc: got %h, want 0005", v);
    end
    run_cycles(10);
    read_count(v);
    n_cmp++;
    if (v !== 16'h0006) begin
      n_bad++; $display("FAIL restart_10cyc: got %h, want 0006", v);
    end
  endtask

  task automatic test_clear;
    logic [15:0] v;
    run_cycles(360);
    read_count(v);
    n_cmp++;
    if (v !== 16'h0042) begin
      n_bad++; $display("FAIL pre_clear_42: got %h, want 0042", v);
    end
    // Clear lands in the tick cycle, then run continues 9 more cycles (one short of a tick).
    @(negedge clk) run = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk) clear = 1'b1;
    @(posedge clk);
    @(negedge clk) clear = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) run = 1'b0;
    read_count(v);
    n_cmp++;
    if (v !== 16'h0000) begin
      n_bad++; $display("FAIL clear_on_tick: got %h, want 0000", v);
    end
    // Clear mid-period must restart the prescaler.
    @(negedge clk) run = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) clear = 1'b1;
    @(posedge clk);
    @(negedge clk) clear = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk) run = 1'b0;
    read_count(v);
    n_cmp++;
    if (v !== 16'h0000) begin
      n_bad++; $display("FAIL clear_prescaler: got %h, want 0000", v);
    end
    run_cycles(10);
    read_count(v);
    n_cmp++;
    if (v !== 16'h0001) begin
      n_bad++; $display("FAIL after_clear_step: got %h, want 0001", v);
    end
  endtask

  task automatic test_async_reset;
    logic [15:0] v;
    bit found;
    run_cycles(3160);
    read_count(v);
    n_cmp++;
    if (v !== 16'h0317) begin
      n_bad++; $display("FAIL pre_reset_317: got %h, want 0317", v);
    end
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge clk);
      if (fnd_digit == 4'b1011) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL reset_align: got digit %b, want 1011", fnd_digit);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (fnd_digit !== 4'b1110 || fnd_data !== 8'hC0) begin
      n_bad++; $display("FAIL async_reset: got %b/%h, want 1110/C0", fnd_digit, fnd_data);
    end
    @(negedge clk) reset = 1'b0;
    read_count(v);
    n_cmp++;
    if (v !== 16'h0000) begin
      n_bad++; $display("FAIL post_reset_count: got %h, want 0000", v);
    end
    run_cycles(10);
    read_count(v);
    n_cmp++;
    if (v !== 16'h0001) begin
      n_bad++; $display("FAIL post_reset_step: got %h, want 0001", v);
    end
  endtask

  initial begin
    test_reset();
    test_count_up_scan();
    test_wrap();
    test_hold();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
